// File: rtl/led_chain_sink.sv
// led_chain_sink: receiver model of a cascaded 16-channel, 12-bit LED driver chain.
// All driver-side pins are oversampled on the system clock. Serial data is shifted in
// on SCLK rises and latched on XLAT rises as a grayscale or dot-correction frame.
// Per-channel PWM is regenerated from GSCLK/BLANK.
module led_chain_sink #(
  parameter int CHIPS = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    led_sclk,
  input  logic                    led_sin,
  input  logic                    led_xlat,
  input  logic                    led_blank,
  input  logic                    led_gsclk,
  input  logic                    led_mode,
  output logic                    led_sout,
  output logic [16*CHIPS-1:0]     pwm_out,
  output logic [6*16*CHIPS-1:0]   dc_out,
  output logic [11:0]             gs_count,
  output logic                    frame_ok,
  output logic                    frame_err
);

  localparam int N       = 16 * CHIPS;
  localparam int GS_BITS = 192 * CHIPS;
  localparam int DC_BITS = 96 * CHIPS;

  localparam logic [9:0]  GS_LEN  = 10'(GS_BITS);
  localparam logic [9:0]  DC_LEN  = 10'(DC_BITS);
  localparam logic [9:0]  CNT_MAX = 10'd1023;
  localparam logic [11:0] GS_MAX  = 12'd4095;

  // Bit positions of the conditioned pins inside the synchronizer vectors.
  localparam int I_SCLK  = 0;
  localparam int I_SIN   = 1;
  localparam int I_XLAT  = 2;
  localparam int I_BLANK = 3;
  localparam int I_GSCLK = 4;
  localparam int I_MODE  = 5;

  // BLANK comes out of reset asserted so the outputs stay dark until the
  // streamer actively releases it.
  localparam logic [5:0] SYNC_RST = 6'b00_1000;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [5:0] pins_s;
  logic [5:0] sync1_q;
  logic [5:0] sync2_q;
  logic [2:0] hist_q;      // {gsclk, xlat, sclk} one stage behind sync2
  logic       sclk_rise_s;
  logic       xlat_rise_s;
  logic       gsclk_rise_s;

  assign pins_s = {led_mode, led_gsclk, led_blank, led_xlat, led_sin, led_sclk};

  // Two-flop synchronizer for every pin plus history flops for the edge-detected strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
      hist_q  <= 3'b000;
    end else begin
      sync1_q <= pins_s;
      sync2_q <= sync1_q;
      hist_q  <= {sync2_q[I_GSCLK], sync2_q[I_XLAT], sync2_q[I_SCLK]};
    end
  end

  assign sclk_rise_s  = sync2_q[I_SCLK]  & ~hist_q[0];
  assign xlat_rise_s  = sync2_q[I_XLAT]  & ~hist_q[1];
  assign gsclk_rise_s = sync2_q[I_GSCLK] & ~hist_q[2];

  // ---------------------------------------------------------------------------
  // Serial shift register and bit counter
  // ---------------------------------------------------------------------------
  logic [GS_BITS-1:0] shift_d;
  logic [GS_BITS-1:0] shift_q;
  logic [9:0]         bit_cnt_d;
  logic [9:0]         bit_cnt_q;

  // Shift left on each SCLK rise; the newest bit enters at bit 0.
  always_comb begin
    shift_d = shift_q;
    if (sclk_rise_s) begin
      shift_d = {shift_q[GS_BITS-2:0], sync2_q[I_SIN]};
    end else begin
      shift_d = shift_q;
    end
  end

  // Count SCLK rises (saturating); an XLAT rise restarts the count, and an SCLK
  // rise in the same cycle already belongs to the next frame.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (xlat_rise_s) begin
      bit_cnt_d = sclk_rise_s ? 10'd1 : 10'd0;
    end else if (sclk_rise_s && (bit_cnt_q != CNT_MAX)) begin
      bit_cnt_d = bit_cnt_q + 10'd1;
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Shift register and bit counter state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= {GS_BITS{1'b0}};
      bit_cnt_q <= 10'd0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame latches and length check
  // ---------------------------------------------------------------------------
  logic [GS_BITS-1:0] gs_latch_d;
  logic [GS_BITS-1:0] gs_latch_q;
  logic [DC_BITS-1:0] dc_latch_d;
  logic [DC_BITS-1:0] dc_latch_q;
  logic               len_ok_s;
  logic               ok_pend_d;
  logic               ok_pend_q;
  logic               err_pend_d;
  logic               err_pend_q;

  // On an XLAT rise compare the bit count with the frame length for the current
  // mode. Only a correctly sized frame is latched, so a short or long burst
  // leaves the previous image intact. The latch always sees pre-shift contents.
  always_comb begin
    gs_latch_d = gs_latch_q;
    dc_latch_d = dc_latch_q;
    len_ok_s   = 1'b0;
    ok_pend_d  = 1'b0;
    err_pend_d = 1'b0;
    if (xlat_rise_s) begin
      if (sync2_q[I_MODE]) begin
        len_ok_s = (bit_cnt_q == DC_LEN);
        if (len_ok_s) begin
          dc_latch_d = shift_q[DC_BITS-1:0];
        end else begin
          dc_latch_d = dc_latch_q;
        end
      end else begin
        len_ok_s = (bit_cnt_q == GS_LEN);
        if (len_ok_s) begin
          gs_latch_d = shift_q;
        end else begin
          gs_latch_d = gs_latch_q;
        end
      end
      ok_pend_d  = len_ok_s;
      err_pend_d = ~len_ok_s;
    end else begin
      ok_pend_d  = 1'b0;
      err_pend_d = 1'b0;
    end
  end

  // Latch registers and the first stage of the frame status pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gs_latch_q <= {GS_BITS{1'b0}};
      dc_latch_q <= {DC_BITS{1'b0}};
      ok_pend_q  <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      gs_latch_q <= gs_latch_d;
      dc_latch_q <= dc_latch_d;
      ok_pend_q  <= ok_pend_d;
      err_pend_q <= err_pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Grayscale counter and PWM
  // ---------------------------------------------------------------------------
  logic [11:0] gs_cnt_d;
  logic [11:0] gs_cnt_q;
  logic        done_d;
  logic        done_q;
  logic [N-1:0] pwm_d;
  logic [N-1:0] pwm_q;

  // BLANK clears the cycle and has priority over a coincident GSCLK rise. The
  // count past 4095 wraps to 0 and sets done, which freezes the cycle until BLANK.
  always_comb begin
    gs_cnt_d = gs_cnt_q;
    done_d   = done_q;
    if (sync2_q[I_BLANK]) begin
      gs_cnt_d = 12'd0;
      done_d   = 1'b0;
    end else if (gsclk_rise_s && !done_q) begin
      if (gs_cnt_q == GS_MAX) begin
        gs_cnt_d = 12'd0;
        done_d   = 1'b1;
      end else begin
        gs_cnt_d = gs_cnt_q + 12'd1;
        done_d   = 1'b0;
      end
    end else begin
      gs_cnt_d = gs_cnt_q;
      done_d   = done_q;
    end
  end

  // A channel is lit while the counter is below its grayscale value, so 0 is
  // never on and 4095 is on for 4095 GSCLK periods.
  always_comb begin
    pwm_d = {N{1'b0}};
    for (int ch = 0; ch < N; ch++) begin
      pwm_d[ch] = ~sync2_q[I_BLANK] & ~done_q & (gs_cnt_q < gs_latch_q[12*ch +: 12]);
    end
  end

  // Grayscale counter state and the registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gs_cnt_q    <= 12'd0;
      done_q      <= 1'b0;
      pwm_q       <= {N{1'b0}};
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      gs_cnt_q    <= gs_cnt_d;
      done_q      <= done_d;
      pwm_q       <= pwm_d;
      frame_ok    <= ok_pend_q;
      frame_err   <= err_pend_q;
    end
  end

  assign led_sout = shift_q[GS_BITS-1];
  assign pwm_out  = pwm_q;
  assign dc_out   = dc_latch_q;
  assign gs_count = gs_cnt_q;

endmodule

// File: tb/tb_led_chain_sink.sv
// Directed bench for led_chain_sink. A behavioural model tracks the serial bit
// stream as a queue, the latched channel values as integer arrays and the PWM
// cycle as a plain counter; a single compare process checks it on every settled cycle.
module tb_led_chain_sink;

  localparam int CHIPS = 3;
  localparam int N     = 16 * CHIPS;
  localparam int GSB   = 192 * CHIPS;
  localparam int DCB   = 96 * CHIPS;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic led_sclk = 1'b0, led_sin = 1'b0, led_xlat = 1'b0;
  logic led_blank = 1'b1, led_gsclk = 1'b0, led_mode = 1'b0;
  logic             led_sout;
  logic [N-1:0]     pwm_out;
  logic [6*N-1:0]   dc_out;
  logic [11:0]      gs_count;
  logic             frame_ok, frame_err;

  always #5 clock = ~clock;

  led_chain_sink #(.CHIPS(CHIPS)) dut (
    .clock(clock), .reset_n(reset_n),
    .led_sclk(led_sclk), .led_sin(led_sin), .led_xlat(led_xlat),
    .led_blank(led_blank), .led_gsclk(led_gsclk), .led_mode(led_mode),
    .led_sout(led_sout), .pwm_out(pwm_out), .dc_out(dc_out),
    .gs_count(gs_count), .frame_ok(frame_ok), .frame_err(frame_err)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model state.
  bit q[$];          // shifted bits, oldest first, at most GSB kept
  int m_cnt = 0;
  int m_gs[N];
  int m_dc[N];
  int m_gscnt = 0;
  bit m_done = 1'b0;
  int m_ok = 0, m_err = 0;
  int seen_ok = 0, seen_err = 0;

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Value held at shift-register position pos (0 = most recently shifted bit).
  function automatic bit qbit(input int pos);
    int idx;
    idx = q.size() - 1 - pos;
    if (idx < 0) return 1'b0;
    return q[idx];
  endfunction

  function automatic int field(input int pos0, input int w);
    int v = 0;
    for (int b = w - 1; b >= 0; b--) v = v * 2 + int'(qbit(pos0 + b));
    return v;
  endfunction

  function automatic logic [N-1:0] exp_pwm();
    logic [N-1:0] e = '0;
    for (int ch = 0; ch < N; ch++) e[ch] = !led_blank && !m_done && (m_gscnt < m_gs[ch]);
    return e;
  endfunction

  function automatic logic [6*N-1:0] exp_dc();
    logic [6*N-1:0] e = '0;
    for (int ch = 0; ch < N; ch++) e[6*ch +: 6] = 6'(m_dc[ch]);
    return e;
  endfunction

  task automatic clear_model();
    q.delete();
    m_cnt = 0; m_gscnt = 0; m_done = 1'b0;
    foreach (m_gs[i]) m_gs[i] = 0;
    foreach (m_dc[i]) m_dc[i] = 0;
  endtask

  // Status pulses are counted and all outputs compared once per settled cycle.
  always @(negedge clock) begin
    if (frame_ok)  seen_ok++;
    if (frame_err) seen_err++;
    if (reset_n) check("ok_err_exclusive", 288'(frame_ok & frame_err), 288'd0);
    if (chk_en && reset_n) begin
      check("sout", 288'(led_sout), 288'(qbit(GSB - 1)));
      check("gs_count", 288'(gs_count), 288'(m_gscnt));
      check("pwm_out", 288'(pwm_out), 288'(exp_pwm()));
      check("dc_out", 288'(dc_out), 288'(exp_dc()));
      check("frame_ok_count", 288'(seen_ok), 288'(m_ok));
      check("frame_err_count", 288'(seen_err), 288'(m_err));
    end
  end

  // Drive one new pin level, let it propagate, then advance the model.
  task automatic step(input bit sc, input bit si, input bit xl, input bit bl, input bit gc, input bit md);
    bit sc_r, xl_r, gc_r;
    sc_r = sc & !led_sclk;
    xl_r = xl & !led_xlat;
    gc_r = gc & !led_gsclk;
    chk_en = 1'b0;
    led_sclk = sc; led_sin = si; led_xlat = xl; led_blank = bl; led_gsclk = gc; led_mode = md;
    repeat (4) @(posedge clock);
    #1;
    if (xl_r) begin
      if (!md) begin
        if (m_cnt == GSB) begin
          m_ok++;
          for (int ch = 0; ch < N; ch++) m_gs[ch] = field(12 * ch, 12);
        end else m_err++;
      end else begin
        if (m_cnt == DCB) begin
          m_ok++;
          for (int ch = 0; ch < N; ch++) m_dc[ch] = field(6 * ch, 6);
        end else m_err++;
      end
      m_cnt = sc_r ? 1 : 0;
    end else if (sc_r && m_cnt < 1023) m_cnt++;
    if (sc_r) begin
      q.push_back(si);
      if (q.size() > GSB) void'(q.pop_front());
    end
    if (bl) begin
      m_gscnt = 0; m_done = 1'b0;
    end else if (gc_r && !m_done) begin
      if (m_gscnt == 4095) begin m_gscnt = 0; m_done = 1'b1; end
      else m_gscnt++;
    end
    chk_en = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic send_vec(input logic [GSB-1:0] v, input int nbits, input bit md);
    for (int i = nbits - 1; i >= 0; i--) begin
      step(1'b0, v[i], 1'b0, led_blank, 1'b0, md);
      step(1'b1, v[i], 1'b0, led_blank, 1'b0, md);
    end
  endtask

  task automatic pulse_xlat(input bit md);
    step(1'b0, led_sin, 1'b1, led_blank, 1'b0, md);
    step(1'b0, led_sin, 1'b0, led_blank, 1'b0, md);
  endtask

  task automatic set_blank(input bit b);
    step(led_sclk, led_sin, led_xlat, b, led_gsclk, led_mode);
  endtask

  task automatic gs_pulse();
    step(led_sclk, led_sin, led_xlat, led_blank, 1'b1, led_mode);
    step(led_sclk, led_sin, led_xlat, led_blank, 1'b0, led_mode);
  endtask

  logic [GSB-1:0] va, vb, vc, vz, vdc;
  logic [6*N-1:0] dc_exp;

  initial begin
    clear_model();
    va = '0; va[575:564] = 12'hABC;
    vb = '0; vb[23:12] = 12'h001; vb[35:24] = 12'hFFF;
    vc = '0; vc[71:60] = 12'h123;
    vz = '0;
    vdc = '0; vdc[287:282] = 6'h15; vdc[5:0] = 6'h3F;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("rst_sout", 288'(led_sout), 288'd0);
    check("rst_pwm", 288'(pwm_out), 288'd0);
    check("rst_dc", 288'(dc_out), 288'd0);
    check("rst_gs_count", 288'(gs_count), 288'd0);
    check("rst_ok_err", 288'({frame_ok, frame_err}), 288'd0);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk_en = 1'b1;

    // Full grayscale frame with channel 47 = 0xABC.
    send_vec(va, GSB, 1'b0);
    pulse_xlat(1'b0);
    check("frameA_ok", 288'(seen_ok), 288'd1);
    check("model_gs47", 288'(m_gs[47]), 288'hABC);
    set_blank(1'b0);
    check("frameA_pwm", 288'(pwm_out), 288'h8000_0000_0000);
    set_blank(1'b1);

    // Short frame is rejected and leaves the image alone.
    send_vec(vz, GSB - 1, 1'b0);
    pulse_xlat(1'b0);
    check("short_err", 288'(seen_err), 288'd1);
    set_blank(1'b0);
    check("short_pwm_kept", 288'(pwm_out), 288'h8000_0000_0000);
    set_blank(1'b1);

    // gs[0]=0, gs[1]=1, gs[2]=4095 through a full PWM cycle.
    send_vec(vb, GSB, 1'b0);
    pulse_xlat(1'b0);
    check("frameB_ok", 288'(seen_ok), 288'd2);
    set_blank(1'b0);
    check("pwm_cnt0", 288'(pwm_out), 288'h6);
    gs_pulse();
    check("pwm_cnt1", 288'(pwm_out), 288'h4);
    for (int i = 0; i < 4094; i++) gs_pulse();
    check("gs_count_4095", 288'(gs_count), 288'hFFF);
    check("pwm_cnt4095", 288'(pwm_out), 288'h0);
    gs_pulse();
    check("gs_count_wrap", 288'(gs_count), 288'd0);
    check("pwm_done", 288'(pwm_out), 288'h0);
    gs_pulse();
    gs_pulse();
    check("done_holds_cnt", 288'(gs_count), 288'd0);
    check("done_holds_pwm", 288'(pwm_out), 288'h0);
    set_blank(1'b1);

    // Dot-correction frame.
    send_vec(vdc, DCB, 1'b1);
    pulse_xlat(1'b1);
    check("dc_ok", 288'(seen_ok), 288'd3);
    dc_exp = '0; dc_exp[287:282] = 6'h15; dc_exp[5:0] = 6'h3F;
    check("dc_value", 288'(dc_out), 288'(dc_exp));
    set_blank(1'b0);
    check("dc_gs_kept", 288'(pwm_out), 288'h6);
    gs_pulse(); gs_pulse(); gs_pulse();
    check("mid_pwm_cnt", 288'(gs_count), 288'd3);
    check("mid_pwm", 288'(pwm_out), 288'h4);

    // Blank mid-PWM: dark and counter cleared within three clocks.
    chk_en = 1'b0;
    led_blank = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("blank_pwm_off", 288'(pwm_out), 288'h0);
    check("blank_cnt_clr", 288'(gs_count), 288'd0);
    m_gscnt = 0; m_done = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_en = 1'b1;

    // XLAT coincident with the first SCLK rise of the next frame.
    send_vec(vc, GSB, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("coinc_ok", 288'(seen_ok), 288'd4);
    check("model_coinc_cnt", 288'(m_cnt), 288'd1);
    set_blank(1'b0);
    check("coinc_pwm", 288'(pwm_out), 288'h20);
    set_blank(1'b1);
    send_vec(vz, GSB - 1, 1'b0);
    pulse_xlat(1'b0);
    check("coinc_next_ok", 288'(seen_ok), 288'd5);

    // Asynchronous reset in the middle of a shift burst.
    set_blank(1'b0);
    send_vec({GSB{1'b1}}, 50, 1'b0);
    chk_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_sout", 288'(led_sout), 288'd0);
    check("arst_pwm", 288'(pwm_out), 288'd0);
    check("arst_dc", 288'(dc_out), 288'd0);
    check("arst_gs_count", 288'(gs_count), 288'd0);
    check("arst_ok_err", 288'({frame_ok, frame_err}), 288'd0);
    led_sclk = 1'b0; led_sin = 1'b0; led_xlat = 1'b0;
    led_blank = 1'b1; led_gsclk = 1'b0; led_mode = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    clear_model();
    repeat (3) @(posedge clock);
    #1;
    chk_en = 1'b1;
    send_vec(va, 10, 1'b0);
    pulse_xlat(1'b0);
    check("post_rst_short_err", 288'(seen_err), 288'd2);
    send_vec(va, GSB, 1'b0);
    pulse_xlat(1'b0);
    check("post_rst_full_ok", 288'(seen_ok), 288'd6);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_chain_sink.md
# led_chain_sink

Cycle-accurate receiver model of one serial LED-driver chain (CHIPS cascaded 16-channel, 12-bit grayscale drivers) sitting on the far end of the led_sclk/led_sin/led_xlat/led_blank/led_gsclk/led_mode interface. It oversamples the driver-side signals on the system clock, shifts in serial data, latches grayscale or dot-correction frames on XLAT, and regenerates per-channel PWM from GSCLK/BLANK. It is used in simulation and on-board loopback to check image streamer output and to drive LED-equivalent outputs.

## Interface
- CHIPS, 3, number of cascaded drivers; channels N = 16*CHIPS, GS frame length = 192*CHIPS bits, DC frame length = 96*CHIPS bits.
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- led_sclk  in  1  serial clock from streamer (asynchronous to clock).
- led_sin  in  1  serial data, MSB first.
- led_xlat  in  1  latch strobe.
- led_blank  in  1  blank; high forces outputs off and clears GS counter.
- led_gsclk  in  1  grayscale PWM clock.
- led_mode  in  1  0 = grayscale frame, 1 = dot-correction frame.
- led_sout  out  1  MSB of shift register (cascade output).
- pwm_out  out  N  per-channel PWM output, channel ch on bit ch.
- dc_out  out  6*N  dot-correction latch, channel ch at [6*ch +: 6].
- gs_count  out  12  current grayscale counter.
- frame_ok  out  1  one-cycle pulse: XLAT with correct bit count.
- frame_err  out  1  one-cycle pulse: XLAT with wrong bit count.

## Operation
- Input conditioning: every led_* input passes through a 2-flop synchronizer plus one history flop; rise = sync2 & ~hist. Synchronizers reset to 0, except led_blank path resets to 1.
- Shift: on sclk rise, shift register (192*CHIPS bits) shifts left, bit 0 <= synchronized sin value at the same stage as sclk. led_sout = bit 192*CHIPS-1.
- Bit counter: 10 bits, increments per sclk rise, saturates at 1023.
- XLAT rise, mode 0: gs_latch <= shift; channel ch value = gs_latch[12*ch +: 12] (first bit shifted lands in MSB of channel N-1). frame_ok if bit count == 192*CHIPS else frame_err. Bit counter cleared.
- XLAT rise, mode 1: dc_latch <= shift[96*CHIPS-1:0]; check against 96*CHIPS. gs_latch untouched.
- XLAT rise and sclk rise in same cycle: latch takes pre-shift contents, check uses pre-increment count, bit counter becomes 1.
- GS counter (12 bits) + done flag: while blank low, each gsclk rise increments counter; increment from 4095 sets done and wraps counter to 0; further gsclk rises ignored until blank. Blank high: counter = 0, done = 0.
- pwm_out[ch] = ~blank_sync & ~done & (gs_count < gs[ch]), registered. gs = 0 never on; gs = 4095 on for 4095 gsclk periods.
- Reset values: all outputs 0, gs_latch/dc_latch/shift/counters 0, done 0.

## Timing
- Input edge at pin sampled at clock edge n takes effect at edge n+2 (state registers update); registered outputs (pwm_out, frame_ok/err) change at edge n+3.
- Inputs must hold each level ≥ 2 clock periods; streamer clocks (8-cycle period, 4 high) meet this.
- frame_ok/frame_err exactly one cycle wide, mutually exclusive, one per XLAT rise.
- Blank rise and gsclk rise same cycle: blank wins (counter 0).
- Async reset mid-frame: everything cleared immediately; first post-reset frame must be full length to give frame_ok.

## Test plan
- CHIPS=3, shift 576 bits with channel 47 = 0xABC, others 0; pulse xlat mode 0 -> frame_ok pulse, gs[47] = 0xABC, gs[0..46] = 0.
- Shift 575 bits then xlat -> frame_err pulse, gs_latch unchanged; next 576-bit frame -> frame_ok.
- gs[0]=0, gs[1]=1, gs[2]=4095; blank low, 4096 gsclk -> pwm_out[0] never high, [1] high 1 gsclk period, [2] high 4095 periods; gs_count wraps to 0 and done holds outputs low until blank.
- Mode 1, 288 bits, xlat -> frame_ok, dc_out loaded, gs_latch unchanged; blank high mid-PWM -> pwm_out 0 within 3 cycles, gs_count 0.
- xlat rise coincident with sclk rise after 576 bits -> frame_ok, latch = pre-shift data, bit counter 1.
- reset_n low mid-shift -> all outputs 0 asynchronously; led_sout 0.
